// File: rtl/vector_pkg.sv
// Shared types and sizing helpers for the vector dot-product datapath.
// Used by the multiply-accumulate sub-module and the dot-product top.
package vector_pkg;

   localparam int DEFAULT_ELEMENT_WIDTH = 24;
   localparam int DEFAULT_FRACTION_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      FINISH,
      OUTPUT
   } dot_state_t;

   // Full-precision product plus enough headroom that a sum of N products never wraps.
   function automatic int acc_width(input int element_width, input int dimension);
      return 2 * element_width + $clog2(dimension);
   endfunction

endpackage

// File: rtl/fixed_point_mac.sv
// Registered unsigned multiply-accumulate: acc is zeroed by clear, otherwise
// adds a*b at full product precision on every enabled edge.
module fixed_point_mac #(
   parameter int ELEMENT_WIDTH = 24,
   parameter int ACC_WIDTH     = 50
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     enable,
   input  logic [ELEMENT_WIDTH-1:0] a,
   input  logic [ELEMENT_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]     acc
);

   logic [2*ELEMENT_WIDTH-1:0] product;

   assign product = {{ELEMENT_WIDTH{1'b0}}, a} * {{ELEMENT_WIDTH{1'b0}}, b};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + ACC_WIDTH'(product);
      end
   end

endmodule

// File: rtl/vector_dot_product_unit.sv
// Pairs two vectors from the dual vector constructor and streams out their
// saturated unsigned fixed-point dot product over a valid/ready handshake.
module vector_dot_product_unit
   import vector_pkg::*;
#(
   parameter int ELEMENT_WIDTH    = DEFAULT_ELEMENT_WIDTH,
   parameter int FRACTION_BITS    = DEFAULT_FRACTION_BITS,
   parameter int VECTOR_DIMENSION = 3,
   parameter int COUNT_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enabled,
   input  logic                     start,
   input  logic [ELEMENT_WIDTH-1:0] first_vector  [0:VECTOR_DIMENSION-1],
   input  logic                     first_vector_ready,
   input  logic [ELEMENT_WIDTH-1:0] second_vector [0:VECTOR_DIMENSION-1],
   input  logic                     second_vector_ready,
   input  logic                     source_done,
   output logic [ELEMENT_WIDTH-1:0] result,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic                     result_overflow,
   output logic                     overrun,
   output logic                     busy,
   output logic [COUNT_WIDTH-1:0]   pair_count,
   output logic                     done
);

   localparam int ACC_WIDTH   = acc_width(ELEMENT_WIDTH, VECTOR_DIMENSION);
   localparam int INDEX_WIDTH = (VECTOR_DIMENSION > 1) ? $clog2(VECTOR_DIMENSION) : 1;
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(VECTOR_DIMENSION - 1);

   dot_state_t state, state_next;

   logic [ELEMENT_WIDTH-1:0] hold_a [0:VECTOR_DIMENSION-1];
   logic [ELEMENT_WIDTH-1:0] hold_b [0:VECTOR_DIMENSION-1];
   logic [ELEMENT_WIDTH-1:0] work_a [0:VECTOR_DIMENSION-1];
   logic [ELEMENT_WIDTH-1:0] work_b [0:VECTOR_DIMENSION-1];
   logic                     a_full, b_full;
   logic [INDEX_WIDTH-1:0]   index;
   logic                     source_done_seen;
   logic                     load;
   logic                     handshake;
   logic                     mac_enable;
   logic [ACC_WIDTH-1:0]     acc;
   logic [ACC_WIDTH-1:0]     scaled;
   logic                     saturate;

   assign handshake  = result_valid && result_ready;
   assign mac_enable = (state == MAC) && enabled;
   assign scaled     = acc >> FRACTION_BITS;
   assign saturate   = |scaled[ACC_WIDTH-1:ELEMENT_WIDTH];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (enabled && a_full && b_full) begin
               load       = 1'b1;
               state_next = MAC;
            end
         end
         MAC: begin
            if (enabled && index == LAST_INDEX) state_next = FINISH;
         end
         FINISH: begin
            if (enabled) state_next = OUTPUT;
         end
         OUTPUT: begin
            // A pair already waiting is loaded on the accepting edge itself.
            if (handshake) begin
               if (enabled && a_full && b_full) begin
                  load       = 1'b1;
                  state_next = MAC;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         index            <= '0;
         a_full           <= 1'b0;
         b_full           <= 1'b0;
         overrun          <= 1'b0;
         source_done_seen <= 1'b0;
         pair_count       <= '0;
         result           <= '0;
         result_overflow  <= 1'b0;
      end else begin
         state <= state_next;

         if (load) begin
            index <= '0;
         end else if (mac_enable && index != LAST_INDEX) begin
            index <= index + INDEX_WIDTH'(1);
         end

         // A strobe landing on the edge that empties its register is still captured.
         if (load) a_full <= first_vector_ready;
         else if (first_vector_ready) a_full <= 1'b1;
         if (load) b_full <= second_vector_ready;
         else if (second_vector_ready) b_full <= 1'b1;

         if (start) overrun <= 1'b0;
         if ((first_vector_ready && a_full && !load) || (second_vector_ready && b_full && !load))
            overrun <= 1'b1;

         if (start) source_done_seen <= 1'b0;
         else if (source_done) source_done_seen <= 1'b1;

         if (start) pair_count <= '0;
         else if (handshake) pair_count <= pair_count + COUNT_WIDTH'(1);

         if (state == FINISH && enabled) begin
            result          <= saturate ? '1 : scaled[ELEMENT_WIDTH-1:0];
            result_overflow <= saturate;
         end
      end
   end

   // NOTE: vector storage carries no reset; the full flags alone say whether its contents mean anything.
   always_ff @(posedge clk) begin
      if (first_vector_ready && (!a_full || load)) hold_a <= first_vector;
      if (second_vector_ready && (!b_full || load)) hold_b <= second_vector;
      if (load) begin
         work_a <= hold_a;
         work_b <= hold_b;
      end
   end

   fixed_point_mac #(
      .ELEMENT_WIDTH(ELEMENT_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clear (load),
      .enable(mac_enable),
      .a     (work_a[index]),
      .b     (work_b[index]),
      .acc   (acc)
   );

   assign result_valid = (state == OUTPUT);
   assign busy         = (state != IDLE) || a_full || b_full;
   assign done         = source_done_seen && (state == IDLE) && !a_full && !b_full;

endmodule
